// File: rtl/uart_tx_frame_pkg.sv
// Shared encodings for the UART frame logic: FSM states and parity modes.
// The receiver uses the same values.
package uart_tx_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } tx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    // 2'b11 is a second "none" code, so test for the two enabled modes explicitly
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_ODD) || (mode == PAR_EVEN);
    endfunction

endpackage

// File: rtl/uart_tx_frame_tick_detect.sv
// Rising-edge detector for the baud generator output; baud_clk is treated as data.
// Produces a one-clk tick for each baud_clk rising edge.
module uart_tx_frame_tick_detect (
    input  logic clk,
    input  logic rst,
    input  logic baud_clk,
    output logic tick
);

    logic baud_prev_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_prev_reg <= 1'b0;
        end else begin
            baud_prev_reg <= baud_clk;
        end
    end

    assign tick = baud_clk & ~baud_prev_reg;

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit serialiser: start bit, LSB-first data, optional parity, stop bit(s),
// advancing one bit per baud tick, with busy/done handshake to the host.
module uart_tx_frame
    import uart_tx_frame_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  baud_clk,
    input  logic                  send,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [1:0]            parity_type,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    logic                  tick;
    tx_state_t             state_reg;
    logic [DATA_WIDTH-1:0] shreg_reg;
    logic [CNT_W-1:0]      bit_cnt_reg;
    logic [1:0]            par_mode_reg;
    logic                  par_acc_reg;
    logic                  stop_cnt_reg;
    logic                  tx_reg;
    logic                  busy_reg;
    logic                  done_reg;

    uart_tx_frame_tick_detect u_tick (
        .clk      (clk),
        .rst      (rst),
        .baud_clk (baud_clk),
        .tick     (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            shreg_reg    <= '0;
            bit_cnt_reg  <= '0;
            par_mode_reg <= PAR_NONE;
            par_acc_reg  <= 1'b0;
            stop_cnt_reg <= 1'b0;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                // A tick coinciding with acceptance is deliberately not consumed
                ST_IDLE: begin
                    tx_reg <= 1'b1;
                    if (send) begin
                        shreg_reg    <= data_in;
                        par_mode_reg <= parity_type;
                        busy_reg     <= 1'b1;
                        state_reg    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (tick) begin
                        tx_reg    <= 1'b0;
                        state_reg <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        tx_reg      <= shreg_reg[0];
                        par_acc_reg <= shreg_reg[0];
                        bit_cnt_reg <= '0;
                        state_reg   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_cnt_reg == LAST_BIT) begin
                            if (parity_enabled(par_mode_reg)) begin
                                tx_reg    <= par_acc_reg ^ (par_mode_reg == PAR_ODD);
                                state_reg <= ST_PARITY;
                            end else begin
                                tx_reg       <= 1'b1;
                                stop_cnt_reg <= 1'b0;
                                state_reg    <= ST_STOP;
                            end
                        end else begin
                            shreg_reg   <= shreg_reg >> 1;
                            tx_reg      <= shreg_reg[1];
                            par_acc_reg <= par_acc_reg ^ shreg_reg[1];
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        tx_reg       <= 1'b1;
                        stop_cnt_reg <= 1'b0;
                        state_reg    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (stop_cnt_reg == LAST_STOP) begin
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= ST_IDLE;
                        end else begin
                            stop_cnt_reg <= stop_cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    tx_reg    <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx   = tx_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: an 8N1-style instance and a 7-bit/2-stop instance, checked every
// cycle against a frame-list model, plus literal frame patterns for directed cases.
module tb_uart_tx_frame;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic baud_clk = 1'b0;

    logic       send_a = 1'b0;
    logic [7:0] data_a = '0;
    logic [1:0] par_a  = '0;
    logic       tx_a, busy_a, done_a;

    logic       send_b = 1'b0;
    logic [6:0] data_b = '0;
    logic [1:0] par_b  = '0;
    logic       tx_b, busy_b, done_b;

    int total = 0;
    int bad   = 0;
    int half  = 2;
    bit baud_run = 1'b1;

    // model state, one slot per instance
    int          dw_of [2] = '{8, 7};
    int          sb_of [2] = '{1, 2};
    logic        m_busy[2] = '{1'b0, 1'b0};
    logic        m_tx  [2] = '{1'b1, 1'b1};
    logic        m_done[2] = '{1'b0, 1'b0};
    logic        m_used[2] = '{1'b0, 1'b0};
    logic        m_acc [2] = '{1'b0, 1'b0};
    logic [15:0] m_bits[2];
    int          m_len [2] = '{0, 0};
    int          m_pos [2] = '{0, 0};
    logic        b_prev = 1'b0;

    logic cap  [2][32];
    int   cap_n[2] = '{0, 0};

    always #5 clk = ~clk;

    uart_tx_frame #(.DATA_WIDTH(8), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .baud_clk(baud_clk), .send(send_a), .data_in(data_a),
        .parity_type(par_a), .tx(tx_a), .busy(busy_a), .done(done_a)
    );

    uart_tx_frame #(.DATA_WIDTH(7), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .baud_clk(baud_clk), .send(send_b), .data_in(data_b),
        .parity_type(par_b), .tx(tx_b), .busy(busy_b), .done(done_b)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Line levels of one whole frame, index 0 = start bit
    function automatic void build_frame(input logic [7:0] d, input logic [1:0] p, input int dw,
                                        input int sb, output logic [15:0] bits, output int len);
        logic x;
        x    = 1'b0;
        bits = '1;
        bits[0] = 1'b0;
        for (int k = 0; k < dw; k++) begin
            bits[k+1] = d[k];
            x = x ^ d[k];
        end
        len = 1 + dw;
        if (p == 2'b01 || p == 2'b10) begin
            bits[len] = (p == 2'b10) ? x : ~x;
            len++;
        end
        len = len + sb;
    endfunction

    function automatic logic [15:0] cap_word(input int i, input int n);
        logic [15:0] w;
        w = '0;
        for (int k = 0; k < n; k++) w = {w[14:0], cap[i][k]};
        return w;
    endfunction

    // baud source: toggles every `half` clk cycles while running
    initial begin
        int bcnt;
        bcnt = 0;
        forever begin
            @(negedge clk);
            if (baud_run) begin
                bcnt++;
                if (bcnt >= half) begin
                    baud_clk = ~baud_clk;
                    bcnt = 0;
                end
            end
        end
    end

    // reference model: each tick while busy puts the next frame bit on the line
    initial begin
        logic       s, tk;
        logic [7:0] d;
        logic [1:0] p;
        forever begin
            @(posedge clk);
            if (!rst) begin
                b_prev = 1'b0;
                for (int i = 0; i < 2; i++) begin
                    m_busy[i] = 1'b0; m_tx[i] = 1'b1; m_done[i] = 1'b0;
                    m_used[i] = 1'b0; m_acc[i] = 1'b0; m_pos[i] = 0;
                end
            end else begin
                tk = baud_clk & ~b_prev;
                b_prev = baud_clk;
                for (int i = 0; i < 2; i++) begin
                    s = (i == 0) ? send_a : send_b;
                    d = (i == 0) ? data_a : {1'b0, data_b};
                    p = (i == 0) ? par_a : par_b;
                    m_done[i] = 1'b0;
                    m_used[i] = 1'b0;
                    m_acc[i]  = 1'b0;
                    if (!m_busy[i]) begin
                        if (s) begin
                            build_frame(d, p, dw_of[i], sb_of[i], m_bits[i], m_len[i]);
                            m_pos[i]  = 0;
                            m_busy[i] = 1'b1;
                            m_acc[i]  = 1'b1;
                        end
                    end else if (tk) begin
                        m_used[i] = 1'b1;
                        if (m_pos[i] < m_len[i]) begin
                            m_tx[i] = m_bits[i][m_pos[i]];
                            m_pos[i]++;
                        end else begin
                            m_busy[i] = 1'b0;
                            m_done[i] = 1'b1;
                            m_tx[i]   = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // compare and capture, away from the active edge
    initial begin
        logic t;
        forever begin
            @(negedge clk);
            check("tx_a", tx_a, m_tx[0]);
            check("busy_a", busy_a, m_busy[0]);
            check("done_a", done_a, m_done[0]);
            check("tx_b", tx_b, m_tx[1]);
            check("busy_b", busy_b, m_busy[1]);
            check("done_b", done_b, m_done[1]);
            for (int i = 0; i < 2; i++) begin
                t = (i == 0) ? tx_a : tx_b;
                if (m_acc[i]) cap_n[i] = 0;
                if (m_used[i] && cap_n[i] < 32) begin
                    cap[i][cap_n[i]] = t;
                    cap_n[i]++;
                end
            end
        end
    end

    task automatic send_frame(input int i, input logic [7:0] d, input logic [1:0] p);
        @(negedge clk);
        if (i == 0) begin
            send_a = 1'b1; data_a = d; par_a = p;
        end else begin
            send_b = 1'b1; data_b = d[6:0]; par_b = p;
        end
        @(negedge clk);
        send_a = 1'b0;
        send_b = 1'b0;
        data_a = 8'($urandom);
        par_a  = 2'($urandom);
        data_b = 7'($urandom);
        par_b  = 2'($urandom);
        $display("frame %0d data=%h parity=%b", i, d, p);
    endtask

    task automatic wait_done(input int i, input string name);
        int n;
        n = 0;
        while (n < 2000) begin
            @(negedge clk);
            if (((i == 0) ? done_a : done_b) === 1'b1) break;
            n++;
        end
        total++;
        if (n >= 2000) begin
            bad++;
            $display("FAIL %s done timeout got=none required=pulse", name);
        end
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_tx", tx_a, 1'b1);
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_tx_b", tx_b, 1'b1);
        rst = 1'b1;
        repeat (20000) @(negedge clk);
        check("idle_tx", tx_a, 1'b1);

        send_frame(0, 8'hA5, 2'b10);
        wait_done(0, "a5_even");
        @(negedge clk);
        check("a5_even_bits", cap_word(0, 11), 11'b01010010101);
        check("a5_even_busy", busy_a, 1'b0);

        send_frame(0, 8'hA5, 2'b01);
        wait_done(0, "a5_odd");
        @(negedge clk);
        check("a5_odd_bits", cap_word(0, 11), 11'b01010010111);

        send_frame(0, 8'h00, 2'b00);
        wait_done(0, "zero_none");
        @(negedge clk);
        check("zero_none_bits", cap_word(0, 10), 10'b0000000001);
        check("zero_none_len", cap_n[0], 11);

        // ignored mid-frame request, then back-to-back on the done cycle
        send_frame(0, 8'h3C, 2'b00);
        repeat (12) @(negedge clk);
        send_a = 1'b1; data_a = 8'hFF; par_a = 2'b10;
        @(negedge clk);
        send_a = 1'b0;
        wait_done(0, "3c");
        check("3c_bits", cap_word(0, 10), 10'b0001111001);
        send_a = 1'b1; data_a = 8'hC3; par_a = 2'b00;
        @(negedge clk);
        send_a = 1'b0;
        n = 1;
        while (tx_a !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("b2b_gap_ok", n <= 2 * half + 1, 1);
        wait_done(0, "c3");
        @(negedge clk);
        check("c3_bits", cap_word(0, 10), 10'b0110000111);

        // asynchronous reset during data bit 4 (bit value 0)
        send_frame(0, 8'hEF, 2'b01);
        n = 0;
        while (cap_n[0] < 6 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("reach_bit4", n < 500, 1);
        #3 rst = 1'b0;
        #1;
        check("async_tx", tx_a, 1'b1);
        check("async_busy", busy_a, 1'b0);
        check("async_done", done_a, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        send_frame(0, 8'h5A, 2'b00);
        wait_done(0, "5a");
        @(negedge clk);
        check("5a_bits", cap_word(0, 10), 10'b0010110101);

        send_frame(1, 8'h41, 2'b00);
        wait_done(1, "w7s2");
        @(negedge clk);
        check("w7s2_bits", cap_word(1, 10), 10'b0100000111);
        check("w7s2_len", cap_n[1], 11);

        // randomized traffic on both instances, with rate changes and baud stalls
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            send_a = ($urandom % 12) == 0;
            data_a = 8'($urandom);
            par_a  = 2'($urandom);
            send_b = ($urandom % 12) == 0;
            data_b = 7'($urandom);
            par_b  = 2'($urandom);
            if ($urandom % 300 == 0) half = $urandom_range(1, 3);
            if ($urandom % 500 == 0) baud_run = 1'b0;
            if (!baud_run && $urandom % 40 == 0) baud_run = 1'b1;
            if (c == 3000) begin
                #3 rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end
        end
        send_a = 1'b0;
        send_b = 1'b0;
        baud_run = 1'b1;
        repeat (200) @(negedge clk);
        check("final_idle_a", busy_a, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
